// File: rtl/alarm_seven_seg_driver.sv
// Seven-segment pin driver: registers the PIO segment pattern and gates it with
// enable, tick-based blinking and PWM brightness, controlled over Avalon-MM.
module alarm_seven_seg_driver #(
   parameter int unsigned TICK_DIV   = 50000,
   parameter int unsigned BLINK_RST  = 500,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic [7:0]  seg_in,
   output logic [7:0]  seg_out,
   output logic        blink_phase
);

   localparam int unsigned   TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [7:0]    SEG_OFF   = {8{ACTIVE_LOW}};

   logic          ctrl_enable;
   logic          ctrl_blink_en;
   logic [3:0]    brightness;
   logic [9:0]    blink_half;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [9:0]    blink_cnt;
   logic [9:0]    blink_limit;
   logic [3:0]    pwm_cnt;
   logic          pwm_on;
   logic [7:0]    seg_in_q;
   logic [7:0]    pattern;
   logic          wr_ctrl;
   logic          wr_half;
   logic          unused_wdata;

   assign wr_ctrl      = chipselect & ~write_n & (address == 2'd0);
   assign wr_half      = chipselect & ~write_n & (address == 2'd1);
   assign unused_wdata = ^{writedata[31:10], writedata[3:2]};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ctrl_enable   <= 1'b1;
         ctrl_blink_en <= 1'b0;
         brightness    <= 4'hF;
         blink_half    <= 10'(BLINK_RST);
      end else begin
         if (wr_ctrl) begin
            ctrl_enable   <= writedata[0];
            ctrl_blink_en <= writedata[1];
            brightness    <= writedata[7:4];
         end
         if (wr_half)
            blink_half <= writedata[9:0];
      end
   end

   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge clk) begin
      if (!reset_n)
         tick_cnt <= '0;
      else if (tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + 1'b1;
   end

   // A BLINK_HALF of 0 is treated as 1, i.e. toggle on every tick.
   assign blink_limit = (blink_half == 10'd0) ? 10'd0 : blink_half - 10'd1;

   // A CTRL write clearing blink_en overrides a coincident toggle; a CTRL write
   // that keeps blink_en set leaves the running blink undisturbed.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (wr_ctrl && !writedata[1]) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (wr_half) begin
         blink_cnt   <= '0;
      end else if (!ctrl_blink_en) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (tick) begin
         if (blink_cnt == blink_limit) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt   <= blink_cnt + 10'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n)
         pwm_cnt <= '0;
      else
         pwm_cnt <= pwm_cnt + 4'd1;
   end

   assign pwm_on  = (brightness == 4'hF) | (pwm_cnt < brightness);
   assign pattern = (ctrl_enable & blink_phase & pwm_on) ? seg_in_q : 8'h00;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         seg_in_q <= '0;
         seg_out  <= SEG_OFF;
      end else begin
         seg_in_q <= seg_in;
         seg_out  <= ACTIVE_LOW ? ~pattern : pattern;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata = {24'h0, brightness, 2'b00, ctrl_blink_en, ctrl_enable};
         2'd1:    readdata = {22'h0, blink_half};
         2'd2:    readdata = {16'h0, seg_in_q, 7'h0, blink_phase};
         default: readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_alarm_seven_seg_driver.sv
// Directed bench for alarm_seven_seg_driver with TICK_DIV=4, ACTIVE_LOW=1.
module tb_alarm_seven_seg_driver;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  seg_in;
   logic [7:0]  seg_out;
   logic        blink_phase;

   int n_checks = 0;
   int n_fail   = 0;

   alarm_seven_seg_driver #(
      .TICK_DIV   (4),
      .BLINK_RST  (500),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .address     (address),
      .chipselect  (chipselect),
      .write_n     (write_n),
      .writedata   (writedata),
      .readdata    (readdata),
      .seg_in      (seg_in),
      .seg_out     (seg_out),
      .blink_phase (blink_phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      step();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   // Steps until blink_phase equals val; n returns the number of steps taken.
   task automatic wait_phase(input string tag, input logic val, output int n);
      n = 0;
      while (blink_phase !== val && n < 40) begin
         step();
         n++;
      end
      check_eq(tag, 32'(blink_phase), 32'(val));
   endtask

   initial begin
      logic [31:0] rd;
      int          n;
      int          lit;

      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      seg_in     = 8'h00;
      step();
      step();
      check_eq("rst_seg_out", 32'(seg_out), 32'hFF);
      check_eq("rst_phase", 32'(blink_phase), 32'h1);
      reset_n = 1'b1;
      step();
      bus_read(2'd0, rd);
      check_eq("rst_ctrl", rd, 32'hF1);
      bus_read(2'd1, rd);
      check_eq("rst_blink_half", rd, 32'd500);

      // Two-stage latency
      seg_in = 8'h3F;
      step();
      check_eq("lat1_seg_out", 32'(seg_out), 32'hFF);
      step();
      check_eq("lat2_seg_out", 32'(seg_out), 32'hC0);
      seg_in = 8'h06;
      step();
      step();
      check_eq("digit1_seg_out", 32'(seg_out), 32'hF9);

      // Blink with BLINK_HALF=2: 8-cycle halves
      seg_in = 8'h3F;
      bus_write(2'd1, 32'd2);
      bus_write(2'd0, 32'hF3);
      check_eq("blink_start_phase", 32'(blink_phase), 32'h1);
      wait_phase("blink_fall0", 1'b0, n);
      check_eq("fall_seg_out_lag", 32'(seg_out), 32'hC0);
      step();
      check_eq("dark_seg_out", 32'(seg_out), 32'hFF);
      wait_phase("blink_rise", 1'b1, n);
      check_eq("dark_len", 32'(n + 1), 32'd8);
      step();
      check_eq("light_seg_out", 32'(seg_out), 32'hC0);
      wait_phase("blink_fall1", 1'b0, n);
      check_eq("light_len", 32'(n + 1), 32'd8);
      step();
      step();
      check_eq("mid_dark_seg_out", 32'(seg_out), 32'hFF);
      bus_write(2'd0, 32'hF1);
      check_eq("unblink_phase", 32'(blink_phase), 32'h1);
      check_eq("unblink_seg_out1", 32'(seg_out), 32'hFF);
      step();
      check_eq("unblink_seg_out2", 32'(seg_out), 32'hC0);

      // Brightness sweep
      seg_in = 8'hFF;
      bus_write(2'd0, 32'h41);
      step();
      step();
      lit = 0;
      for (int i = 0; i < 16; i++) begin
         if (seg_out == 8'h00) lit++;
         step();
      end
      check_eq("bright4_lit", 32'(lit), 32'd4);
      bus_write(2'd0, 32'h01);
      step();
      step();
      lit = 0;
      for (int i = 0; i < 16; i++) begin
         if (seg_out == 8'h00) lit++;
         step();
      end
      check_eq("bright0_lit", 32'(lit), 32'd0);
      bus_write(2'd0, 32'hF1);
      step();
      step();
      lit = 0;
      for (int i = 0; i < 16; i++) begin
         if (seg_out == 8'h00) lit++;
         step();
      end
      check_eq("bright15_lit", 32'(lit), 32'd16);

      // BLINK_HALF=0 behaves as 1
      bus_write(2'd1, 32'd0);
      bus_write(2'd0, 32'hF3);
      wait_phase("half0_fall0", 1'b0, n);
      wait_phase("half0_rise", 1'b1, n);
      check_eq("half0_dark_len", 32'(n), 32'd4);
      wait_phase("half0_fall1", 1'b0, n);
      check_eq("half0_light_len", 32'(n), 32'd4);

      // Reserved and read-only addresses
      bus_write(2'd3, 32'h0);
      bus_read(2'd0, rd);
      check_eq("addr3_ctrl_kept", rd, 32'hF3);
      bus_read(2'd3, rd);
      check_eq("addr3_reads0", rd, 32'h0);
      bus_write(2'd2, 32'h0000_0005);
      bus_read(2'd0, rd);
      check_eq("addr2_ctrl_kept", rd, 32'hF3);
      bus_read(2'd1, rd);
      check_eq("addr2_half_kept", rd, 32'h0);
      bus_read(2'd2, rd);
      check_eq("status_upper", {rd[31:16], 8'h0, rd[15:8]}, 32'h0000_00FF);

      // Reset in the dark half of a blink
      wait_phase("pre_reset_fall", 1'b0, n);
      reset_n = 1'b0;
      step();
      check_eq("midrst_seg_out", 32'(seg_out), 32'hFF);
      check_eq("midrst_phase", 32'(blink_phase), 32'h1);
      bus_read(2'd0, rd);
      check_eq("midrst_ctrl", rd, 32'hF1);
      bus_read(2'd1, rd);
      check_eq("midrst_half", rd, 32'd500);
      bus_read(2'd2, rd);
      check_eq("midrst_status", rd, 32'h0000_0001);
      reset_n = 1'b1;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
